// File: rtl/divider_sequential_pkg.sv
// Shared types and constants for the sequential signed divider.
package divider_sequential_pkg;

    localparam int unsigned DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Counter must hold values 0..W.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DIV_W);

endpackage

// File: rtl/divider_sequential_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface divider_sequential_if
    import divider_sequential_pkg::*;
#(
    parameter int unsigned W = DIV_W
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_sequential_div_restoring_step.sv
// One restoring-division step: shift {rem, quo} left and conditionally subtract.
module divider_sequential_div_restoring_step
    import divider_sequential_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);
    logic [W:0] rem_sh;
    logic [W:0] trial;

    // rem < dvs <= 2^(W-1), so the shifted remainder never overflows W+1 bits.
    always_comb begin
        rem_sh = {rem_i, quo_i[W-1]};
        trial  = rem_sh - {1'b0, dvs_i};
        if (!trial[W]) begin
            rem_o = trial[W-1:0];
            quo_o = {quo_i[W-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[W-1:0];
            quo_o = {quo_i[W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/divider_sequential.sv
// Iterative signed divider: sign-magnitude restoring division, one quotient bit per clock.
module divider_sequential
    import divider_sequential_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic                 clk,
    input  logic                 rst,
    divider_sequential_if.slave  bus
);
    localparam int unsigned CW = cnt_width(W);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;
    logic          dz_q, dz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  quotient_q, quotient_d;
    logic [W-1:0]  remainder_q, remainder_d;
    logic          div_by_zero_q, div_by_zero_d;

    logic          a_neg, b_neg;
    logic [W-1:0]  a_mag, b_mag;
    logic [W-1:0]  step_rem, step_quo;
    logic [W-1:0]  quo_signed, rem_signed, dvd_signed;

    divider_sequential_div_restoring_step #(.W(W)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Magnitudes; the most-negative value maps to 2^(W-1) as an unsigned W-bit value.
    always_comb begin
        a_neg = bus.dividend[W-1];
        b_neg = bus.divisor[W-1];
        a_mag = a_neg ? W'(W'(0) - bus.dividend) : bus.dividend;
        b_mag = b_neg ? W'(W'(0) - bus.divisor)  : bus.divisor;
    end

    // Sign correction; on divide-by-zero quo_q still holds |dividend|.
    always_comb begin
        quo_signed = q_neg_q ? W'(W'(0) - quo_q) : quo_q;
        rem_signed = r_neg_q ? W'(W'(0) - rem_q) : rem_q;
        dvd_signed = r_neg_q ? W'(W'(0) - quo_q) : quo_q;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dz_d          = dz_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dz_d    = (bus.divisor == '0);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (bus.divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = CW'(cnt_q + CW'(1));
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d        = 1'b1;
                busy_d        = 1'b0;
                div_by_zero_d = dz_q;
                quotient_d    = dz_q ? '1 : quo_signed;
                remainder_d   = dz_q ? dvd_signed : rem_signed;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dz_q          <= dz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_divider_sequential.sv
// Directed and soak bench for the sequential signed divider.
module tb_divider_sequential;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divider_sequential_if #(.W(W)) bus ();

    divider_sequential #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Called right after a negedge; start is seen by the following posedge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 32'hDEADBEEF;
        bus.divisor  = 32'h0BADF00D;
    endtask

    // Returns edges after the accepting edge until done, and busy cycles seen.
    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            if (bus.busy === 1'b1) busy_n++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            err_cnt++;
            $display("FAIL reset: got busy=%b done=%b q=%h r=%h dz=%b, want all zero",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n, bn;
        launch(32'd100, 32'd7);
        wait_done(n, bn);
        vec_cnt++;
        if (n !== 33) begin err_cnt++; $display("FAIL basic_latency: got %0d want 33", n); end
        vec_cnt++;
        if (bn !== 33) begin err_cnt++; $display("FAIL basic_busy_cycles: got %0d want 33", bn); end
        vec_cnt++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
            err_cnt++;
            $display("FAIL basic_100_7: got q=%0d r=%0d dz=%b want q=14 r=2 dz=0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        vec_cnt++;
        if ({bus.done, bus.busy, bus.quotient} !== {1'b0, 1'b0, 32'd14}) begin
            err_cnt++;
            $display("FAIL done_pulse_hold: got done=%b busy=%b q=%0d want done=0 busy=0 q=14",
                     bus.done, bus.busy, bus.quotient);
        end
    endtask

    task automatic test_signs();
        int av[7], bv[7], qv[7], rv[7];
        int n, bn;
        av = '{-100, 100, -100, int'(32'h80000000), int'(32'h80000000), 7, -7};
        bv = '{7, -7, -7, -1, 1, 100, 100};
        qv = '{-14, -14, 14, int'(32'h80000000), int'(32'h80000000), 0, 0};
        rv = '{-2, 2, -2, 0, 0, 7, -7};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            launch(32'(av[i]), 32'(bv[i]));
            wait_done(n, bn);
            vec_cnt++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'(qv[i]), 32'(rv[i]), 1'b0}) begin
                err_cnt++;
                $display("FAIL signs[%0d] %0d/%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=0",
                         i, av[i], bv[i], bus.quotient, bus.remainder, bus.div_by_zero,
                         32'(qv[i]), 32'(rv[i]));
            end
        end
    endtask

    task automatic test_div_zero();
        int n, bn;
        @(negedge clk);
        launch(32'd55, 32'd0);
        wait_done(n, bn);
        vec_cnt++;
        if (n !== 1) begin err_cnt++; $display("FAIL dz_latency: got %0d want 1", n); end
        vec_cnt++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'hFFFFFFFF, 32'd55, 1'b1}) begin
            err_cnt++;
            $display("FAIL dz_55: got q=%h r=%h dz=%b want q=ffffffff r=00000037 dz=1",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        launch(32'hFFFFFFC9, 32'd0);
        wait_done(n, bn);
        vec_cnt++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'hFFFFFFFF, 32'hFFFFFFC9, 1'b1}) begin
            err_cnt++;
            $display("FAIL dz_neg55: got q=%h r=%h dz=%b want q=ffffffff r=ffffffc9 dz=1",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        launch(32'd9, 32'd3);
        wait_done(n, bn);
        vec_cnt++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'd3, 32'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL dz_clear_9_3: got q=%h r=%h dz=%b want q=3 r=0 dz=0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int n, bn, extra;
        @(negedge clk);
        launch(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, bn);
        vec_cnt++;
        if (10 + n !== 33) begin err_cnt++; $display("FAIL ignore_latency: got %0d want 33", 10 + n); end
        vec_cnt++;
        if ({bus.quotient, bus.remainder} !== {32'd333, 32'd1}) begin
            err_cnt++;
            $display("FAIL ignore_1000_3: got q=%0d r=%0d want q=333 r=1", bus.quotient, bus.remainder);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        vec_cnt++;
        if (extra !== 0) begin err_cnt++; $display("FAIL ignore_no_queue: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int n, bn;
        @(negedge clk);
        launch(32'd100, 32'd7);
        wait_done(n, bn);
        vec_cnt++;
        if (bus.quotient !== 32'd14) begin err_cnt++; $display("FAIL b2b_first: got q=%0d want 14", bus.quotient); end
        launch(32'hFFFFFFF9, 32'd2);
        wait_done(n, bn);
        vec_cnt++;
        if (n !== 33) begin err_cnt++; $display("FAIL b2b_latency: got %0d want 33", n); end
        vec_cnt++;
        if ({bus.quotient, bus.remainder} !== {32'hFFFFFFFD, 32'hFFFFFFFF}) begin
            err_cnt++;
            $display("FAIL b2b_neg7_2: got q=%h r=%h want q=fffffffd r=ffffffff", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_abort();
        int n, bn, seen;
        @(negedge clk);
        launch(32'd1000, 32'd3);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vec_cnt++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            err_cnt++;
            $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h dz=%b want all zero",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        vec_cnt++;
        if (seen !== 0) begin err_cnt++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        launch(32'd77, 32'hFFFFFFFB);
        wait_done(n, bn);
        vec_cnt++;
        if ({bus.quotient, bus.remainder} !== {32'hFFFFFFF1, 32'd2}) begin
            err_cnt++;
            $display("FAIL abort_restart_77_neg5: got q=%h r=%h want q=fffffff1 r=00000002",
                     bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_soak();
        logic [W-1:0] a, b;
        int ai, bi, qe, re, n, bn;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if (i % 2 == 1) b = 32'($urandom_range(0, 200)) - 32'd100;
            else            b = $urandom >> (i % 20);
            if (b == '0) b = 32'd1;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            ai = int'(a);
            bi = int'(b);
            qe = ai / bi;
            re = ai % bi;
            @(negedge clk);
            launch(a, b);
            wait_done(n, bn);
            vec_cnt++;
            if ({bus.quotient, bus.remainder} !== {32'(qe), 32'(re)}) begin
                err_cnt++;
                $display("FAIL soak[%0d] %h/%h: got q=%h r=%h want q=%h r=%h",
                         i, a, b, bus.quotient, bus.remainder, 32'(qe), 32'(re));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
